sipo_receiver: RTL and testbench
================================

# sipo_receiver

Serial-to-parallel receiver that assembles a framed serial bit stream into WIDTH-bit words and presents them on a valid/ready output with a one-word holding register. It is the receiving end of the parallel-to-serial path of our 4-bit shift register: a word shifted out one bit per clock is rebuilt here. Overruns are detected and flagged rather than silently overwriting held data.

## Interface
- WIDTH, 4: word width in bits; legal range 2–32.
- MSB_FIRST, 1: 1 = first received bit lands in d_out[WIDTH-1]; 0 = first received bit lands in d_out[0].
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  qualifies s_in; a bit is sampled only on an edge where s_valid=1.
- s_first  input  1  marks the sampled bit as bit 0 of a new word; meaningful only with s_valid=1.
- d_out  output  WIDTH  assembled word from the holding register.
- d_valid  output  1  holding register contains an unconsumed word.
- d_ready  input  1  consumer accepts d_out on an edge where d_valid=1 and d_ready=1.
- overrun  output  1  sticky; a completed word was dropped because the holding register was full.
- clr_ovr  input  1  synchronous clear of overrun.

## Operation
- Reset (async assert, sync-safe release): state=IDLE, bit counter=0, shift register=0, d_out=0, d_valid=0, overrun=0.
- FSM states: IDLE (no partial word), SHIFT (partial word held, counter = bits received).
- IDLE: s_valid & s_first -> store bit, counter=1, go SHIFT. s_valid without s_first -> bit dropped, stay IDLE. No s_valid -> stay.
- SHIFT: s_valid & ~s_first -> shift bit in, counter+1. s_valid & s_first -> resync: discard partial word, store bit as bit 0, counter=1, stay SHIFT. No s_valid -> hold (gaps of any length allowed).
- Word completion: the edge sampling bit WIDTH-1 (counter==WIDTH-1, s_valid=1, s_first=0) loads {partial, s_in} into the holding register if it is free, sets counter=0, goes IDLE.
- Holding register is free if d_valid=0, or d_valid=1 and d_ready=1 on the same edge (accept-and-reload; d_valid stays 1, no overrun).
- Completion with d_valid=1 and d_ready=0: new word dropped, d_out unchanged, overrun set; state still returns to IDLE.
- d_ready with d_valid=0: ignored. Acceptance without completion: d_valid cleared, d_out keeps last value.
- Edge with completion on WIDTH=… and s_first=1: s_first wins (resync), no word completes.
- overrun: set on drop, cleared by clr_ovr; if drop and clr_ovr coincide, overrun ends the edge set (set wins).
- Bit order: MSB_FIRST=1 shifts left (first bit -> MSB); MSB_FIRST=0 shifts right (first bit -> LSB).
- Counter width: $clog2(WIDTH); never exceeds WIDTH-1.

## Timing
- Latency: d_out/d_valid update on the same edge that samples the last bit; visible in the following cycle.
- Throughput: one word per WIDTH s_valid cycles, back-to-back with no bubble if d_ready stays high.
- d_out stable while d_valid=1 and not accepted.
- All outputs registered; no combinational path from inputs to outputs.
- Reset mid-word: partial word, held word, and overrun lost immediately; first valid bit after release must carry s_first.

## Structure
- Package sipo_pkg: typedef enum logic {IDLE, SHIFT} sipo_state_t.
- Single module; no sub-module — FSM, counter, shift register and holding register are small and tightly coupled.

## Test plan
- WIDTH=4, MSB_FIRST=1, d_ready=1: bits 1,1,0,1 (s_first on first) -> d_out=4'b1101, d_valid high one cycle after 4th sampled edge, low after acceptance.
- MSB_FIRST=0, bits 1,1,0,1 -> d_out=4'b1011.
- d_ready=0: send 0101 then 0011 -> d_out stays 4'b0101, overrun=1; clr_ovr pulse -> overrun=0; second word never appears.
- Resync: bits 1,0 then s_first with 0,1,1,0 -> d_out=4'b0110; partial 10 discarded.
- Gaps and back-to-back: 1010 with s_valid idle cycles between bits, then 0111 immediately, d_ready=1 -> two words 4'b1010, 4'b0111, d_valid continuous across the reload edge, overrun=0.
- Reset asserted after 2 bits of 1100, released, then full 1001 -> all outputs 0 during reset, then d_out=4'b1001, overrun=0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types for the serial-to-parallel receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_receiver.sv
// Rebuilds framed serial bits into WIDTH-bit words behind a one-word holding
// register with valid/ready hand-off and a sticky overrun flag.
//
// state | meaning
// IDLE  | no partial word; only a bit carrying s_first starts a word
// SHIFT | partial word held; cnt_q = number of bits received so far
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_first,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sipo_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             d_valid_q, d_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] seeded;
    logic             drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            dout_q    <= '0;
            d_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            dout_q    <= dout_d;
            d_valid_q <= d_valid_d;
            overrun_q <= overrun_d;
        end
    end

    // The partial word grows from the LSB end (MSB-first) or the MSB end
    // (LSB-first), so after WIDTH bits the first bit sits in its final place.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], s_in};
            seeded  = {{(WIDTH-1){1'b0}}, s_in};
        end else begin
            shifted = {s_in, sr_q[WIDTH-1:1]};
            seeded  = {s_in, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        dout_d    = dout_q;
        d_valid_d = d_valid_q & ~d_ready;
        drop      = 1'b0;

        if (s_valid) begin
            if (s_first) begin
                sr_d    = seeded;
                cnt_d   = CNT_W'(1);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q == LAST_BIT) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    // Free slot, or the held word leaves on this same edge.
                    if (!d_valid_q || d_ready) begin
                        dout_d    = shifted;
                        d_valid_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        overrun_d = drop | (overrun_q & ~clr_ovr);
    end

    assign d_out   = dout_q;
    assign d_valid = d_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench: an MSB-first and an LSB-first receiver share one stimulus stream.
module tb_sipo_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_in, s_valid, s_first, d_ready, clr_ovr;
    logic [3:0] d_out_m, d_out_l;
    logic       d_valid_m, d_valid_l, overrun_m, overrun_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_m (
        .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .s_first(s_first),
        .d_out(d_out_m), .d_valid(d_valid_m), .d_ready(d_ready),
        .overrun(overrun_m), .clr_ovr(clr_ovr)
    );

    sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_l (
        .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .s_first(s_first),
        .d_out(d_out_l), .d_valid(d_valid_l), .d_ready(d_ready),
        .overrun(overrun_l), .clr_ovr(clr_ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic b, input logic first);
        s_valid = 1'b1;
        s_in    = b;
        s_first = first;
        cyc();
        s_valid = 1'b0;
        s_first = 1'b0;
        s_in    = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        send(w[3], 1'b1);
        send(w[2], 1'b0);
        send(w[1], 1'b0);
        send(w[0], 1'b0);
    endtask

    task automatic check_both(input string tag, input logic [3:0] exp_m, input logic [3:0] exp_l,
                              input logic exp_v, input logic exp_o);
        check({tag, "_dout_m"}, d_out_m, exp_m);
        check({tag, "_dout_l"}, d_out_l, exp_l);
        check({tag, "_valid_m"}, d_valid_m, exp_v);
        check({tag, "_valid_l"}, d_valid_l, exp_v);
        check({tag, "_ovr_m"}, overrun_m, exp_o);
        check({tag, "_ovr_l"}, overrun_l, exp_o);
    endtask

    initial begin
        reset = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_first = 1'b0;
        d_ready = 1'b0; clr_ovr = 1'b0;
        cyc();
        check_both("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();

        // Basic word, consumer always ready
        d_ready = 1'b1;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        check_both("basic_pre", 4'b0000, 4'b0000, 1'b0, 1'b0);
        send(1'b1, 1'b0);
        check_both("basic_word", 4'b1101, 4'b1011, 1'b1, 1'b0);
        cyc();
        check_both("basic_accept", 4'b1101, 4'b1011, 1'b0, 1'b0);

        // Overrun: consumer stalled
        d_ready = 1'b0;
        send_word(4'b0101);
        check_both("ovr_first", 4'b0101, 4'b1010, 1'b1, 1'b0);
        send_word(4'b0011);
        check_both("ovr_drop", 4'b0101, 4'b1010, 1'b1, 1'b1);
        cyc();
        check_both("ovr_sticky", 4'b0101, 4'b1010, 1'b1, 1'b1);
        clr_ovr = 1'b1;
        cyc();
        clr_ovr = 1'b0;
        check_both("ovr_clear", 4'b0101, 4'b1010, 1'b1, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        clr_ovr = 1'b1;
        send(1'b1, 1'b0);
        clr_ovr = 1'b0;
        check_both("ovr_set_wins", 4'b0101, 4'b1010, 1'b1, 1'b1);
        clr_ovr = 1'b1;
        d_ready = 1'b1;
        cyc();
        clr_ovr = 1'b0;
        check_both("ovr_drain", 4'b0101, 4'b1010, 1'b0, 1'b0);
        cyc();
        check_both("ready_idle", 4'b0101, 4'b1010, 1'b0, 1'b0);

        // Stray bit in IDLE, then resync mid-word
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        check_both("resync_mid", 4'b0101, 4'b1010, 1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        check_both("resync_word", 4'b0110, 4'b0110, 1'b1, 1'b0);
        cyc();

        // Gapped word held, then back-to-back word reloads on acceptance edge
        d_ready = 1'b0;
        send(1'b1, 1'b1);
        cyc(); cyc();
        send(1'b0, 1'b0);
        cyc();
        send(1'b1, 1'b0);
        cyc(); cyc(); cyc();
        check_both("gap_mid", 4'b0110, 4'b0110, 1'b0, 1'b0);
        send(1'b0, 1'b0);
        check_both("gap_word", 4'b1010, 4'b0101, 1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        check_both("b2b_hold", 4'b1010, 4'b0101, 1'b1, 1'b0);
        d_ready = 1'b1;
        send(1'b1, 1'b0);
        d_ready = 1'b0;
        check_both("b2b_reload", 4'b0111, 4'b1110, 1'b1, 1'b0);

        // Reset mid-word with a word held and overrun set
        send_word(4'b0000);
        check_both("pre_reset", 4'b0111, 4'b1110, 1'b1, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_both("reset_async", 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        cyc();
        check_both("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        d_ready = 1'b1;
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        check_both("post_reset_mid", 4'b0000, 4'b0000, 1'b0, 1'b0);
        send(1'b1, 1'b0);
        check_both("post_reset_word", 4'b1001, 4'b1001, 1'b1, 1'b0);
        cyc();
        check_both("post_reset_accept", 4'b1001, 4'b1001, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
